// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, RV32I opcodes and the opcode/funct decode function.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic       illegal;
    logic       alu_src;
    logic       zero_a;
    logic [3:0] alu_op;
  } dec_t;

  // alt selects SUB for f3=000 and SRA for f3=101
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode_aluop(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic funct7b5);
    dec_t d;
    d = '{illegal: 1'b0, alu_src: 1'b0, zero_a: 1'b0, alu_op: ALU_ADD};
    case (opcode)
      OPC_R: d.alu_op = f3_op(funct3, funct7b5);
      OPC_I_ALU: begin
        d.alu_op  = f3_op(funct3, funct7b5 && funct3 == 3'b101);
        d.alu_src = 1'b1;
      end
      OPC_LOAD, OPC_STORE: d.alu_src = 1'b1;
      OPC_BRANCH: d.alu_op = ALU_SUB;
      OPC_LUI: begin
        d.alu_src = 1'b1;
        d.zero_a  = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_if: decoder, ALU and EX/MEM-side signals of the issue stage.
interface alu_issue_if #(parameter int XLEN = 32);
  logic            flush;
  logic            dec_valid;
  logic            dec_ready;
  logic [6:0]      dec_opcode;
  logic [2:0]      dec_funct3;
  logic            dec_funct7b5;
  logic [XLEN-1:0] dec_rs1_data;
  logic [XLEN-1:0] dec_rs2_data;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] operand_A;
  logic [XLEN-1:0] operand_B;
  logic [XLEN-1:0] immediate;
  logic [3:0]      ALUOp;
  logic            ALUSrc;
  logic [XLEN-1:0] ALU_Result;
  logic            zero;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_result;
  logic            ex_zero;
  logic [4:0]      ex_rd;
  logic            ex_illegal;

  modport slave (
    input  flush, dec_valid, dec_opcode, dec_funct3, dec_funct7b5, dec_rs1_data, dec_rs2_data,
           dec_imm, dec_rd, ALU_Result, zero, ex_ready,
    output dec_ready, operand_A, operand_B, immediate, ALUOp, ALUSrc, ex_valid, ex_result,
           ex_zero, ex_rd, ex_illegal
  );

  modport master (
    output flush, dec_valid, dec_opcode, dec_funct3, dec_funct7b5, dec_rs1_data, dec_rs2_data,
           dec_imm, dec_rd, ALU_Result, zero, ex_ready,
    input  dec_ready, operand_A, operand_B, immediate, ALUOp, ALUSrc, ex_valid, ex_result,
           ex_zero, ex_rd, ex_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode/funct to ALU control decode.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output dec_t       dec
);
  always_comb dec = decode_aluop(opcode, funct3, funct7b5);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-slot ID/EX issue and EX/MEM result pipeline with backpressure and flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       reset,
  alu_issue_if.slave bus
);
  dec_t       d;
  logic       s1_valid;
  logic       s1_illegal;
  logic [4:0] s1_rd;
  logic       advance;
  logic       accept;

  alu_op_decode u_dec (
    .opcode  (bus.dec_opcode),
    .funct3  (bus.dec_funct3),
    .funct7b5(bus.dec_funct7b5),
    .dec     (d)
  );

  assign advance       = s1_valid && (!bus.ex_valid || bus.ex_ready);
  assign bus.dec_ready = !s1_valid || advance;
  assign accept        = bus.dec_valid && bus.dec_ready;

  // data registers only move on accept/advance so the ALU sees stable inputs while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_illegal     <= 1'b0;
      s1_rd          <= '0;
      bus.operand_A  <= '0;
      bus.operand_B  <= '0;
      bus.immediate  <= '0;
      bus.ALUOp      <= ALU_ADD;
      bus.ALUSrc     <= 1'b0;
      bus.ex_valid   <= 1'b0;
      bus.ex_result  <= '0;
      bus.ex_zero    <= 1'b0;
      bus.ex_rd      <= '0;
      bus.ex_illegal <= 1'b0;
    end else begin
      if (accept) begin
        bus.operand_A <= d.zero_a ? {XLEN{1'b0}} : bus.dec_rs1_data;
        bus.operand_B <= bus.dec_rs2_data;
        bus.immediate <= bus.dec_imm;
        bus.ALUOp     <= d.alu_op;
        bus.ALUSrc    <= d.alu_src;
        s1_rd         <= bus.dec_rd;
        s1_illegal    <= d.illegal;
      end
      if (advance) begin
        bus.ex_result  <= bus.ALU_Result;
        bus.ex_zero    <= bus.zero;
        bus.ex_rd      <= s1_rd;
        bus.ex_illegal <= s1_illegal;
      end
      s1_valid     <= bus.flush ? 1'b0 : accept ? 1'b1 : advance ? 1'b0 : s1_valid;
      bus.ex_valid <= bus.flush ? 1'b0 : advance ? 1'b1 : bus.ex_ready ? 1'b0 : bus.ex_valid;
    end
  end
endmodule
